// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM read engine: command encodings,
// default timing constants and the engine state enum.
package sdram_pkg;

  // {we_n, cas_n, ras_n}
  typedef enum logic [2:0] {
    CMD_NOP          = 3'b111,
    CMD_ACTIVE       = 3'b110,
    CMD_READ         = 3'b101,
    CMD_PRECHARGE    = 3'b010,
    CMD_AUTO_REFRESH = 3'b100
  } cmd_t;

  localparam int T_RCD_DEF   = 2;
  localparam int CAS_LAT_DEF = 2;
  localparam int T_RP_DEF    = 2;
  localparam int T_RFC_DEF   = 7;

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACTIVATE,
    S_RCD_WAIT,
    S_FIFO_WAIT,
    S_READ_CMD,
    S_CAS_WAIT,
    S_CAPTURE0,
    S_CAPTURE1,
    S_PUSH,
    S_PRECHARGE,
    S_RP_WAIT,
    S_REFRESH,
    S_RFC_WAIT
  } state_t;

endpackage

// File: rtl/sdram_read_ctrl_if.sv
// Request, SDRAM pin and read-FIFO signals of the single-read engine.
// slave = the read engine, master = parent controller / FIFO / SDRAM side.
interface sdram_read_ctrl_if;
  import sdram_pkg::*;

  logic        en;
  logic [21:0] address;
  logic        auto_refresh;
  logic        ready;
  cmd_t        command;
  logic [11:0] addr;
  logic [1:0]  bank;
  logic [1:0]  data_mask;
  logic [15:0] data_in;
  logic [31:0] fifo_data;
  logic        fifo_full;
  logic        fifo_wr;

  modport slave (
    input  en, address, auto_refresh, data_in, fifo_full,
    output ready, command, addr, bank, data_mask, fifo_data, fifo_wr
  );

  modport master (
    output en, address, auto_refresh, data_in, fifo_full,
    input  ready, command, addr, bank, data_mask, fifo_data, fifo_wr
  );

endinterface

// File: rtl/sdram_read_ctrl.sv
// Single-read engine: ACTIVE, READ, two-beat capture into one 32-bit FIFO word,
// row close and auto-refresh. `SDRAM_RD_AUTO_PRECHARGE_EN selects A10 auto precharge.
//
// state             | meaning
// IDLE / ACTIVATE   | ready, waiting for en or refresh / ACTIVE on the pins
// RCD_WAIT/FIFO_WAIT| tRCD gap / row open, holding off while the FIFO is full
// READ_CMD/CAS_WAIT | READ on the pins / waiting out CAS latency
// CAPTURE0/CAPTURE1 | edge at the end of the state samples beat0 / beat1
// PUSH / PRECHARGE  | fifo_wr strobe / explicit row close (no auto precharge)
// RP_WAIT           | tRP recovery before returning to IDLE
// REFRESH/RFC_WAIT  | AUTO_REFRESH on the pins / tRFC recovery
module sdram_read_ctrl
  import sdram_pkg::*;
#(
  parameter int T_RCD   = T_RCD_DEF,
  parameter int CAS_LAT = CAS_LAT_DEF,
  parameter int T_RP    = T_RP_DEF,
  parameter int T_RFC   = T_RFC_DEF
) (
  input logic clk,
  input logic rst,
  sdram_read_ctrl_if.slave bus
);

`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
  localparam logic A10 = 1'b1;
`else
  localparam logic A10 = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_load;
  logic [21:0]       lat_q, lat_d;
  logic [15:0]       beat0_q;
  cmd_t              cmd_q, cmd_d;
  logic [11:0]       addr_q, addr_d;
  logic [1:0]        bank_q, bank_d;
  logic [31:0]       fifo_data_q, fifo_data_d;
  logic              fifo_wr_q, fifo_wr_d;
  logic              ready_q, ready_d;
  logic              ref_pend_q, ref_clr;
  logic              go_read;

  assign go_read = (state_q == S_IDLE) && !ref_pend_q && bus.en;
  assign ref_clr = ((state_q == S_REFRESH) || (state_q == S_RFC_WAIT)) && (state_d == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= cnt_load;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = '0;
    case (state_q)
      S_IDLE:      if (ref_pend_q) state_d = S_REFRESH;
                   else if (bus.en) state_d = S_ACTIVATE;
      S_ACTIVATE:  if (T_RCD > 1) state_d = S_RCD_WAIT;
                   else state_d = bus.fifo_full ? S_FIFO_WAIT : S_READ_CMD;
      S_RCD_WAIT:  if (cnt_q == '0) state_d = bus.fifo_full ? S_FIFO_WAIT : S_READ_CMD;
      S_FIFO_WAIT: if (!bus.fifo_full) state_d = S_READ_CMD;
      S_READ_CMD:  state_d = S_CAS_WAIT;
      S_CAS_WAIT:  if (cnt_q == '0) state_d = S_CAPTURE0;
      S_CAPTURE0:  state_d = S_CAPTURE1;
      S_CAPTURE1:  state_d = S_PUSH;
`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
      S_PUSH:      state_d = S_RP_WAIT;
`else
      S_PUSH:      state_d = S_PRECHARGE;
`endif
      S_PRECHARGE: state_d = S_RP_WAIT;
      S_RP_WAIT:   if (cnt_q == '0) state_d = S_IDLE;
      S_REFRESH:   state_d = (T_RFC > 1) ? S_RFC_WAIT : S_IDLE;
      S_RFC_WAIT:  if (cnt_q == '0) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // wait states last (load + 1) cycles; the counter runs down to terminal count 0
    case (state_d)
      S_RCD_WAIT: cnt_load = CNT_W'(T_RCD - 2);
      S_CAS_WAIT: cnt_load = CNT_W'(CAS_LAT - 2);
      S_RP_WAIT:  cnt_load = CNT_W'(T_RP - 1);
      S_RFC_WAIT: cnt_load = CNT_W'(T_RFC - 2);
      default:    cnt_load = '0;
    endcase
  end

  // Outputs are decoded from the next state so the pins change on the entry edge.
  always_comb begin
    lat_d       = go_read ? bus.address : lat_q;
    cmd_d       = CMD_NOP;
    addr_d      = '0;
    bank_d      = bank_q;
    ready_d     = (state_d == S_IDLE);
    fifo_wr_d   = (state_d == S_PUSH);
    fifo_data_d = fifo_wr_d ? {beat0_q, bus.data_in} : fifo_data_q;
    case (state_d)
      S_ACTIVATE: begin
        cmd_d  = CMD_ACTIVE;
        bank_d = lat_d[21:20];
        addr_d = lat_d[19:8];
      end
      S_READ_CMD: begin
        cmd_d  = CMD_READ;
        bank_d = lat_q[21:20];
        addr_d = {1'b0, A10, 2'b00, lat_q[7:0]};
      end
      S_PRECHARGE: begin
        cmd_d  = CMD_PRECHARGE;
        bank_d = lat_q[21:20];
      end
      S_REFRESH:  cmd_d = CMD_AUTO_REFRESH;
      default:    cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_q       <= '0;
      beat0_q     <= '0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      bank_q      <= '0;
      fifo_data_q <= '0;
      fifo_wr_q   <= 1'b0;
      ready_q     <= 1'b1;
      ref_pend_q  <= 1'b0;
    end else begin
      lat_q       <= lat_d;
      if (state_q == S_CAPTURE0)
        beat0_q   <= bus.data_in;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      bank_q      <= bank_d;
      fifo_data_q <= fifo_data_d;
      fifo_wr_q   <= fifo_wr_d;
      ready_q     <= ready_d;
      ref_pend_q  <= bus.auto_refresh | (ref_pend_q & ~ref_clr);
    end
  end

  assign bus.command   = cmd_q;
  assign bus.addr      = addr_q;
  assign bus.bank      = bank_q;
  assign bus.data_mask = 2'b00;
  assign bus.fifo_data = fifo_data_q;
  assign bus.fifo_wr   = fifo_wr_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_sdram_read_ctrl.sv
// Directed bench for sdram_read_ctrl: table of read transactions plus hand-written
// refresh-priority and mid-operation reset sequences. Honours SDRAM_RD_AUTO_PRECHARGE_EN.
module tb_sdram_read_ctrl;

  localparam int T_RCD   = 2;
  localparam int CAS_LAT = 2;
  localparam int T_RP    = 2;
  localparam int T_RFC   = 7;
`ifdef SDRAM_RD_AUTO_PRECHARGE_EN
  localparam int AP = 1;
`else
  localparam int AP = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  sdram_read_ctrl_if bus();

  sdram_read_ctrl #(
    .T_RCD(T_RCD), .CAS_LAT(CAS_LAT), .T_RP(T_RP), .T_RFC(T_RFC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [21:0] address;
    logic [15:0] b0;
    logic [15:0] b1;
    int          stall;
    int          ref_k;
    int          reen_k;
    logic [1:0]  e_bank;
    logic [11:0] e_row;
    logic [11:0] e_rd_ap;
    logic [11:0] e_rd_np;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[4];

  // k counts negedges after edge E0 (the edge that samples en).
  task automatic do_read(input vec_t v, output int ready_k);
    int act_k, rd_k, wr_k, pre_k, n_act, n_rd, n_wr;
    logic [31:0] wr_data;
    logic [1:0]  act_bank, pre_bank;
    logic [11:0] act_addr, rd_addr;
    act_k = -1; rd_k = -1; wr_k = -1; pre_k = -1;
    n_act = 0; n_rd = 0; n_wr = 0;
    wr_data = '0; act_bank = '0; pre_bank = '0; act_addr = '0; rd_addr = '0;
    ready_k = -1;
    @(negedge clk);
    bus.en = 1'b1;
    bus.address = v.address;
    for (int k = 0; k < 40 && ready_k < 0; k++) begin
      @(negedge clk);
      if (bus.command == 3'b110) begin
        n_act++;
        if (act_k < 0) begin act_k = k; act_bank = bus.bank; act_addr = bus.addr; end
      end
      if (bus.command == 3'b101) begin
        n_rd++;
        if (rd_k < 0) begin rd_k = k; rd_addr = bus.addr; end
      end
      if (bus.command == 3'b010 && pre_k < 0) begin pre_k = k; pre_bank = bus.bank; end
      if (bus.fifo_wr) begin
        n_wr++;
        wr_k = k;
        wr_data = bus.fifo_data;
      end
      if (bus.ready) ready_k = k;
      bus.en = (k == v.reen_k);
      if (k == v.reen_k) bus.address = ~v.address;
      bus.auto_refresh = (k == v.ref_k);
      bus.fifo_full = (v.stall > 0 && k >= 1 && k <= v.stall);
      if (rd_k >= 0 && k == rd_k + CAS_LAT)          bus.data_in = v.b0;
      else if (rd_k >= 0 && k == rd_k + CAS_LAT + 1) bus.data_in = v.b1;
      else                                           bus.data_in = 16'hDEAD;
    end
    bus.en = 1'b0;
    bus.auto_refresh = 1'b0;
    bus.fifo_full = 1'b0;
    bus.data_in = 16'hDEAD;
    check("act_cycle", 32'(act_k), 32'd0);
    check("act_bank", 32'(act_bank), 32'(v.e_bank));
    check("act_row", 32'(act_addr), 32'(v.e_row));
    check("n_active", 32'(n_act), 32'd1);
    check("rd_cycle", 32'(rd_k), 32'(T_RCD + v.stall));
    check("rd_addr", 32'(rd_addr), 32'(AP ? v.e_rd_ap : v.e_rd_np));
    check("n_read", 32'(n_rd), 32'd1);
    check("wr_cycle", 32'(wr_k), 32'(T_RCD + v.stall + CAS_LAT + 2));
    check("n_wr", 32'(n_wr), 32'd1);
    check("wr_data", wr_data, v.e_data);
    check("ready_cycle", 32'(ready_k), 32'(T_RCD + CAS_LAT + 3 + T_RP + v.stall + (AP ? 0 : 1)));
    check("fifo_hold", bus.fifo_data, v.e_data);
    if (!AP) begin
      check("pre_cycle", 32'(pre_k), 32'(T_RCD + v.stall + CAS_LAT + 3));
      check("pre_bank", 32'(pre_bank), 32'(v.e_bank));
    end
  endtask

  task automatic check_refresh(input string tag);
    int low;
    check({tag, "_cmd"}, 32'(bus.command), 32'(3'b100));
    check({tag, "_ready0"}, 32'(bus.ready), 32'd0);
    low = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ready) break;
      if (bus.command != 3'b111) check({tag, "_rfc_nop"}, 32'(bus.command), 32'(3'b111));
      low++;
    end
    check({tag, "_low_cycles"}, 32'(low), 32'(T_RFC));
  endtask

  initial begin
    int rk, n_act, n_wr, n_cmd;
    vecs[0] = '{22'h2ABC5D, 16'h1234, 16'h5678, 0, -1, -1, 2'd2, 12'hABC, 12'h45D, 12'h05D, 32'h12345678};
    vecs[1] = '{22'h3FFFFF, 16'hFFFF, 16'h0001, 0, -1,  4, 2'd3, 12'hFFF, 12'h4FF, 12'h0FF, 32'hFFFF0001};
    vecs[2] = '{22'h100A01, 16'hA5A5, 16'h5A5A, 5, -1, -1, 2'd1, 12'h00A, 12'h401, 12'h001, 32'hA5A55A5A};
    vecs[3] = '{22'h2ABC5D, 16'hCAFE, 16'hBEEF, 0,  3, -1, 2'd2, 12'hABC, 12'h45D, 12'h05D, 32'hCAFEBEEF};

    rst = 1'b0;
    bus.en = 1'b0;
    bus.address = '0;
    bus.auto_refresh = 1'b0;
    bus.fifo_full = 1'b0;
    bus.data_in = 16'hDEAD;
    #12;
    check("rst_cmd", 32'(bus.command), 32'(3'b111));
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
    check("rst_fifo_data", bus.fifo_data, 32'd0);
    check("rst_addr_bank", {18'd0, bus.bank, bus.addr}, 32'd0);
    check("data_mask", 32'(bus.data_mask), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_read(vecs[i], rk);
      if (vecs[i].ref_k >= 0) begin
        @(negedge clk);
        check_refresh("rd_then_ref");
      end
      repeat (2) @(negedge clk);
    end

    // Pending refresh wins over a same-cycle en; en is dropped.
    bus.auto_refresh = 1'b1;
    @(negedge clk);
    bus.auto_refresh = 1'b0;
    bus.en = 1'b1;
    bus.address = 22'h2ABC5D;
    @(negedge clk);
    bus.en = 1'b0;
    check_refresh("en_vs_ref");
    n_act = 0; n_wr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.command == 3'b110) n_act++;
      if (bus.fifo_wr) n_wr++;
    end
    check("en_dropped_act", 32'(n_act), 32'd0);
    check("en_dropped_wr", 32'(n_wr), 32'd0);
    check("en_dropped_ready", 32'(bus.ready), 32'd1);

    // Asynchronous reset in the middle of a read.
    bus.en = 1'b1;
    bus.address = 22'h100A01;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cmd", 32'(bus.command), 32'(3'b111));
    check("mid_rst_ready", 32'(bus.ready), 32'd1);
    check("mid_rst_fifo_data", bus.fifo_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n_wr = 0; n_cmd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.fifo_wr) n_wr++;
      if (bus.command != 3'b111) n_cmd++;
    end
    check("mid_rst_no_push", 32'(n_wr), 32'd0);
    check("mid_rst_no_cmd", 32'(n_cmd), 32'd0);
    check("mid_rst_idle", 32'(bus.ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
